div_stall_unit: RTL

DIV_STALL_UNIT -- requirements
Module: div_stall_unit

---
 rtl/div_stall_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/div_stall_unit.sv
// Multi-cycle 32-bit restoring divider that stalls EX until its result is ready.
// Optional macro DIV_EARLY_OUT_EN: a zero divisor skips the 32 iterations (FREE->ZERO->END).
module div_stall_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_ZERO = 2'd1,
    ST_ON   = 2'd2,
    ST_END  = 2'd3
  } state_t;

  state_t      state_r;
  logic [5:0]  cnt_r;
  logic        signed_r;
  logic        dividend_neg_r;
  logic        divisor_neg_r;
  logic        divisor_zero_r;
  logic [31:0] dividend_r;
  logic [31:0] divisor_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;

  logic [32:0] shift_s;
  logic [32:0] diff_s;
  logic [31:0] rem_next_s;
  logic [31:0] quo_next_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;
  logic [63:0] final_s;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? neg32(v) : v;
  endfunction

  assign stallreq_o = start_i & ~ready_o;

  // One restoring step plus the sign/zero fix-up applied on the last iteration
  always_comb begin
    shift_s    = {rem_r, quo_r[31]};
    diff_s     = shift_s - {1'b0, divisor_r};
    rem_next_s = shift_s[31:0];
    quo_next_s = {quo_r[30:0], 1'b0};
    if (!diff_s[32]) begin
      rem_next_s = diff_s[31:0];
      quo_next_s = {quo_r[30:0], 1'b1};
    end else begin
      rem_next_s = shift_s[31:0];
      quo_next_s = {quo_r[30:0], 1'b0};
    end

    if (signed_r && (dividend_neg_r ^ divisor_neg_r)) begin
      quo_fix_s = neg32(quo_next_s);
    end else begin
      quo_fix_s = quo_next_s;
    end

    if (signed_r && dividend_neg_r) begin
      rem_fix_s = neg32(rem_next_s);
    end else begin
      rem_fix_s = rem_next_s;
    end

    if (divisor_zero_r) begin
      final_s = {dividend_r, 32'hFFFF_FFFF};
    end else begin
      final_s = {rem_fix_s, quo_fix_s};
    end
  end

  // Control FSM, operand latches, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_FREE;
      cnt_r          <= 6'd0;
      ready_o        <= 1'b0;
      result_o       <= 64'h0;
      signed_r       <= 1'b0;
      dividend_neg_r <= 1'b0;
      divisor_neg_r  <= 1'b0;
      divisor_zero_r <= 1'b0;
      dividend_r     <= 32'd0;
      divisor_r      <= 32'd0;
      rem_r          <= 32'd0;
      quo_r          <= 32'd0;
    end else begin
      case (state_r)
        ST_FREE: begin
          ready_o  <= 1'b0;
          result_o <= 64'h0;
          cnt_r    <= 6'd0;
          if (start_i && !annul_i) begin
            signed_r       <= signed_i;
            dividend_neg_r <= signed_i & opdata1_i[31];
            divisor_neg_r  <= signed_i & opdata2_i[31];
            divisor_zero_r <= (opdata2_i == 32'd0);
            dividend_r     <= opdata1_i;
            divisor_r      <= abs32(opdata2_i, signed_i);
            rem_r          <= 32'd0;
            quo_r          <= abs32(opdata1_i, signed_i);
`ifdef DIV_EARLY_OUT_EN
            state_r        <= (opdata2_i == 32'd0) ? ST_ZERO : ST_ON;
`else
            state_r        <= ST_ON;
`endif
          end else begin
            state_r <= ST_FREE;
          end
        end
        ST_ZERO: begin
          if (annul_i) begin
            state_r  <= ST_FREE;
            ready_o  <= 1'b0;
            result_o <= 64'h0;
          end else begin
            state_r  <= ST_END;
            ready_o  <= 1'b1;
            result_o <= {dividend_r, 32'hFFFF_FFFF};
          end
        end
        ST_ON: begin
          // start_i is guaranteed held here, so only annul_i can abort
          if (annul_i) begin
            state_r  <= ST_FREE;
            cnt_r    <= 6'd0;
            ready_o  <= 1'b0;
            result_o <= 64'h0;
          end else if (cnt_r == 6'd31) begin
            state_r  <= ST_END;
            cnt_r    <= 6'd0;
            rem_r    <= rem_next_s;
            quo_r    <= quo_next_s;
            ready_o  <= 1'b1;
            result_o <= final_s;
          end else begin
            state_r  <= ST_ON;
            cnt_r    <= cnt_r + 6'd1;
            rem_r    <= rem_next_s;
            quo_r    <= quo_next_s;
            ready_o  <= 1'b0;
            result_o <= 64'h0;
          end
        end
        ST_END: begin
          if (!start_i) begin
            state_r  <= ST_FREE;
            ready_o  <= 1'b0;
            result_o <= 64'h0;
          end else begin
            state_r  <= ST_END;
            ready_o  <= 1'b1;
            result_o <= result_o;
          end
        end
        default: begin
          state_r  <= ST_FREE;
          cnt_r    <= 6'd0;
          ready_o  <= 1'b0;
          result_o <= 64'h0;
        end
      endcase
    end
  end

endmodule
